// File: rtl/alu_issue_stage_if.sv
// Bundle of the upstream issue handshake, the ALU drive/return lines and the
// downstream result handshake for alu_issue_stage.
interface alu_issue_stage_if #(
  parameter int IMM_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_func;
  logic [15:0]      in_rs;
  logic [15:0]      in_rt;
  logic [IMM_W-1:0] in_imm;
  logic             in_use_imm;

  logic [15:0]      alu_a;
  logic [15:0]      alu_b;
  logic [2:0]       alu_op;
  logic [15:0]      alu_r;
  logic             alu_zero;

  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_result;
  logic             out_zero;
  logic             out_illegal;
  logic [15:0]      ops_done;

  modport slave (
    input  in_valid, in_func, in_rs, in_rt, in_imm, in_use_imm,
    input  alu_r, alu_zero, out_ready,
    output in_ready, alu_a, alu_b, alu_op,
    output out_valid, out_result, out_zero, out_illegal, ops_done
  );

  modport master (
    output in_valid, in_func, in_rs, in_rt, in_imm, in_use_imm,
    output alu_r, alu_zero, out_ready,
    input  in_ready, alu_a, alu_b, alu_op,
    input  out_valid, out_result, out_zero, out_illegal, ops_done
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Execute-stage front end: decodes an operation, drives the ALU from registers,
// waits a fixed settle time, captures the result and hands it downstream.
module alu_issue_stage #(
  parameter int IMM_W         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset,
  alu_issue_stage_if.slave bus
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_DRIVE  = 2'd1;
  localparam logic [1:0]  S_RESP   = 2'd2;
  localparam logic [3:0]  LAST_CNT = 4'(SETTLE_CYCLES - 1);
  localparam logic [15:0] IMM_MASK = 16'((32'd1 << IMM_W) - 32'd1);

  // Returns {legal, alu_op}; the ALU's op encoding is not contiguous.
  function automatic logic [3:0] decode_func(input logic [3:0] func);
    case (func)
      4'd0:    return 4'b1_000;
      4'd1:    return 4'b1_001;
      4'd2:    return 4'b1_010;
      4'd3:    return 4'b1_110;
      4'd4:    return 4'b1_100;
      default: return 4'b0_000;
    endcase
  endfunction

  function automatic logic signed [15:0] extend_imm(input logic [IMM_W-1:0] imm,
                                                    input logic            sext);
    logic signed [15:0] zx;
    zx = 16'(imm);
    return (sext && imm[IMM_W-1]) ? (zx | ~IMM_MASK) : zx;
  endfunction

  logic [1:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic signed [15:0] alu_a_q, alu_a_d;
  logic signed [15:0] alu_b_q, alu_b_d;
  logic [2:0]         alu_op_q, alu_op_d;
  logic [15:0]        res_q, res_d;
  logic               zero_q, zero_d;
  logic               ill_q, ill_d;
  logic [15:0]        ops_q, ops_d;

  logic [3:0]         dec;
  logic signed [15:0] b_sel;

  assign dec   = decode_func(bus.in_func);
  // Logical ops zero-extend the immediate; arithmetic and compare sign-extend.
  assign b_sel = bus.in_use_imm ? extend_imm(bus.in_imm, |dec[2:1])
                                : $signed(bus.in_rt);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    zero_d   = zero_q;
    ill_d    = ill_q;
    ops_d    = ops_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (dec[3]) begin
            alu_a_d  = $signed(bus.in_rs);
            alu_b_d  = b_sel;
            alu_op_d = dec[2:0];
            cnt_d    = 4'd0;
            state_d  = S_DRIVE;
          end else begin
            res_d   = 16'h0000;
            zero_d  = 1'b1;
            ill_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_DRIVE: begin
        if (cnt_q == LAST_CNT) begin
          res_d   = bus.alu_r;
          zero_d  = bus.alu_zero;
          ill_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (bus.out_ready) begin
          ops_d   = ops_q + 16'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= 3'd0;
      res_q    <= 16'h0000;
      zero_q   <= 1'b0;
      ill_q    <= 1'b0;
      ops_q    <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      ill_q    <= ill_d;
      ops_q    <= ops_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE) && !reset;
  assign bus.out_valid   = (state_q == S_RESP);
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.out_result  = res_q;
  assign bus.out_zero    = zero_q;
  assign bus.out_illegal = ill_q;
  assign bus.ops_done    = ops_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus randomized ops checked
// against a functional model of decode, operand selection and ALU arithmetic.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.IMM_W(8)) b1 ();
  alu_issue_stage_if #(.IMM_W(8)) b3 ();

  // Behavioural stand-in for the downstream ALU.
  function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd4:    return (a < b) ? 16'd1 : 16'd0;
      3'd6:    return a - b;
      default: return 16'h0000;
    endcase
  endfunction

  assign b1.alu_r    = alu_fn(b1.alu_a, b1.alu_b, b1.alu_op);
  assign b1.alu_zero = (b1.alu_r == 16'h0000);
  assign b3.alu_r    = alu_fn(b3.alu_a, b3.alu_b, b3.alu_op);
  assign b3.alu_zero = (b3.alu_r == 16'h0000);

  alu_issue_stage #(.IMM_W(8), .SETTLE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  alu_issue_stage #(.IMM_W(8), .SETTLE_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));

  int errors = 0;
  int checks = 0;
  logic [15:0] ops_m;

  // Functional model: what a function code means, independent of op encoding.
  task automatic ref_model(input logic [3:0] f, input logic [15:0] rs, input logic [15:0] rt,
                           input logic [7:0] imm, input logic ui,
                           output logic legal, output logic [15:0] b, output logic [2:0] op,
                           output logic [15:0] res, output logic zero);
    if (!ui)                    b = rt;
    else if (f == 0 || f == 1)  b = {8'h00, imm};
    else                        b = {{8{imm[7]}}, imm};
    legal = 1'b1;
    op    = 3'd0;
    case (f)
      4'd0: begin res = rs & b; op = 3'd0; end
      4'd1: begin res = rs | b; op = 3'd1; end
      4'd2: begin res = rs + b; op = 3'd2; end
      4'd3: begin res = rs - b; op = 3'd6; end
      4'd4: begin res = (rs < b) ? 16'd1 : 16'd0; op = 3'd4; end
      default: begin res = 16'h0000; legal = 1'b0; end
    endcase
    zero = (res == 16'h0000);
  endtask

  // Issues one op on dut1 and returns the number of edges after the accept
  // edge until out_valid is seen.
  task automatic run_op(input logic [3:0] f, input logic [15:0] rs, input logic [15:0] rt,
                        input logic [7:0] imm, input logic ui, output int lat);
    int n;
    @(negedge clk);
    b1.in_func = f; b1.in_rs = rs; b1.in_rt = rt; b1.in_imm = imm; b1.in_use_imm = ui;
    b1.in_valid = 1'b1;
    n = 0;
    while (!b1.in_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    lat = 0;
    while (!b1.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic accept_out();
    @(negedge clk);
    b1.out_ready = 1'b1;
    @(posedge clk); #1;
    b1.out_ready = 1'b0;
    ops_m = ops_m + 16'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    b1.in_valid = 0; b1.in_func = 0; b1.in_rs = 0; b1.in_rt = 0; b1.in_imm = 0; b1.in_use_imm = 0; b1.out_ready = 0;
    b3.in_valid = 0; b3.in_func = 0; b3.in_rs = 0; b3.in_rt = 0; b3.in_imm = 0; b3.in_use_imm = 0; b3.out_ready = 0;
    ops_m = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({b1.in_ready, b1.out_valid} !== 2'b00) begin errors++; $display("FAIL reset_ctrl: got %b expected 00", {b1.in_ready, b1.out_valid}); end
    checks++; if ({b1.alu_a, b1.alu_b, b1.alu_op, b1.out_result, b1.out_zero, b1.out_illegal, b1.ops_done} !== 69'd0) begin
      errors++; $display("FAIL reset_data: got a=%h b=%h op=%h r=%h z=%b i=%b n=%h expected all 0",
                         b1.alu_a, b1.alu_b, b1.alu_op, b1.out_result, b1.out_zero, b1.out_illegal, b1.ops_done); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", b1.in_ready); end
  endtask

  task automatic test_add();
    int lat;
    run_op(4'd2, 16'h1234, 16'h0F0F, 8'h00, 1'b0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d expected 1", lat); end
    checks++; if ({b1.alu_op, b1.alu_a, b1.alu_b} !== {3'd2, 16'h1234, 16'h0F0F}) begin errors++; $display("FAIL add_alu_drive: got op=%h a=%h b=%h expected 2 1234 0f0f", b1.alu_op, b1.alu_a, b1.alu_b); end
    checks++; if ({b1.out_result, b1.out_zero, b1.out_illegal} !== {16'h2143, 2'b00}) begin errors++; $display("FAIL add_result: got r=%h z=%b i=%b expected 2143 0 0", b1.out_result, b1.out_zero, b1.out_illegal); end
    accept_out();
    checks++; if (b1.ops_done !== 16'd1) begin errors++; $display("FAIL add_ops_done: got %h expected 0001", b1.ops_done); end
    checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL add_valid_drop: got %b expected 0", b1.out_valid); end
  endtask

  task automatic test_imm_ext();
    int lat;
    run_op(4'd3, 16'h0005, 16'h0000, 8'hFB, 1'b1, lat);
    checks++; if ({b1.alu_op, b1.alu_b} !== {3'd6, 16'hFFFB}) begin errors++; $display("FAIL sub_imm_sext: got op=%h b=%h expected 6 fffb", b1.alu_op, b1.alu_b); end
    checks++; if (b1.out_result !== 16'h000A) begin errors++; $display("FAIL sub_imm_result: got %h expected 000a", b1.out_result); end
    accept_out();
    run_op(4'd0, 16'h0F0F, 16'h0000, 8'hFB, 1'b1, lat);
    checks++; if ({b1.alu_op, b1.alu_b} !== {3'd0, 16'h00FB}) begin errors++; $display("FAIL and_imm_zext: got op=%h b=%h expected 0 00fb", b1.alu_op, b1.alu_b); end
    checks++; if (b1.out_result !== 16'h000B) begin errors++; $display("FAIL and_imm_result: got %h expected 000b", b1.out_result); end
    accept_out();
  endtask

  task automatic test_illegal();
    int lat;
    run_op(4'd9, 16'hAAAA, 16'h5555, 8'h11, 1'b0, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL illegal_latency: got %0d expected 0", lat); end
    checks++; if ({b1.out_result, b1.out_zero, b1.out_illegal} !== {16'h0000, 2'b11}) begin errors++; $display("FAIL illegal_result: got r=%h z=%b i=%b expected 0000 1 1", b1.out_result, b1.out_zero, b1.out_illegal); end
    checks++; if ({b1.alu_op, b1.alu_a, b1.alu_b} !== {3'd0, 16'h0F0F, 16'h00FB}) begin errors++; $display("FAIL illegal_alu_hold: got op=%h a=%h b=%h expected 0 0f0f 00fb", b1.alu_op, b1.alu_a, b1.alu_b); end
    accept_out();
    checks++; if (b1.ops_done !== ops_m) begin errors++; $display("FAIL illegal_ops_done: got %h expected %h", b1.ops_done, ops_m); end
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(4'd3, 16'h7777, 16'h7777, 8'h00, 1'b0, lat);
    b1.in_func = 4'd2; b1.in_rs = 16'h1111; b1.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({b1.out_valid, b1.out_result, b1.out_zero, b1.in_ready, b1.ops_done, b1.alu_a} !== {1'b1, 16'h0000, 1'b1, 1'b0, ops_m, 16'h7777}) begin
        errors++; $display("FAIL hold_cycle%0d: got v=%b r=%h z=%b rdy=%b n=%h a=%h expected 1 0000 1 0 %h 7777",
                           i, b1.out_valid, b1.out_result, b1.out_zero, b1.in_ready, b1.ops_done, b1.alu_a, ops_m); end
    end
    b1.in_valid = 1'b0;
    accept_out();
    checks++; if (b1.ops_done !== ops_m) begin errors++; $display("FAIL hold_ops_done: got %h expected %h", b1.ops_done, ops_m); end
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    b1.in_func = 4'd2; b1.in_rs = 16'h0001; b1.in_rt = 16'h0002; b1.in_use_imm = 1'b0; b1.in_valid = 1'b1;
    @(posedge clk); #1;
    b1.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    ops_m = 16'd0;
    checks++; if ({b1.out_valid, b1.in_ready, b1.ops_done, b1.alu_a, b1.alu_b, b1.alu_op} !== 53'd0) begin
      errors++; $display("FAIL midreset_state: got v=%b rdy=%b n=%h a=%h b=%h op=%h expected all 0",
                         b1.out_valid, b1.in_ready, b1.ops_done, b1.alu_a, b1.alu_b, b1.alu_op); end
    @(negedge clk); reset = 1'b0;
    run_op(4'd2, 16'h0010, 16'h0020, 8'h00, 1'b0, lat);
    checks++; if ({lat == 1, b1.out_result} !== {1'b1, 16'h0030}) begin errors++; $display("FAIL midreset_first_op: got lat=%0d r=%h expected 1 0030", lat, b1.out_result); end
    accept_out();
    checks++; if (b1.ops_done !== 16'd1) begin errors++; $display("FAIL midreset_ops_done: got %h expected 0001", b1.ops_done); end
  endtask

  task automatic test_random();
    logic [3:0] f; logic [15:0] rs, rt; logic [7:0] imm; logic ui;
    logic legal, ez; logic [15:0] eb, er; logic [2:0] eop;
    logic [15:0] ma, mb; logic [2:0] mo;
    int lat;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); reset = 1'b0;
    ops_m = 16'd0; ma = 16'd0; mb = 16'd0; mo = 3'd0;
    for (int it = 0; it < 60; it++) begin
      f   = 4'($urandom_range(0, 6));
      rs  = 16'($urandom);
      rt  = ($urandom_range(0, 5) == 0) ? rs : 16'($urandom);
      imm = 8'($urandom);
      ui  = 1'($urandom);
      ref_model(f, rs, rt, imm, ui, legal, eb, eop, er, ez);
      if (legal) begin ma = rs; mb = eb; mo = eop; end
      run_op(f, rs, rt, imm, ui, lat);
      checks++; if (lat !== (legal ? 1 : 0)) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, lat, legal ? 1 : 0); end
      checks++; if ({b1.out_result, b1.out_zero, b1.out_illegal} !== {er, ez, !legal}) begin
        errors++; $display("FAIL rand%0d_result f=%0d: got r=%h z=%b i=%b expected %h %b %b", it, f, b1.out_result, b1.out_zero, b1.out_illegal, er, ez, !legal); end
      checks++; if ({b1.alu_a, b1.alu_b, b1.alu_op} !== {ma, mb, mo}) begin
        errors++; $display("FAIL rand%0d_alu f=%0d: got a=%h b=%h op=%h expected %h %h %h", it, f, b1.alu_a, b1.alu_b, b1.alu_op, ma, mb, mo); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      accept_out();
      checks++; if (b1.ops_done !== ops_m) begin errors++; $display("FAIL rand%0d_ops_done: got %h expected %h", it, b1.ops_done, ops_m); end
    end
  endtask

  task automatic test_wrap();
    int lat;
    @(negedge clk);
    force dut1.ops_q = 16'hFFFF;
    @(posedge clk); #1;
    release dut1.ops_q;
    @(negedge clk);
    checks++; if (b1.ops_done !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffff", b1.ops_done); end
    run_op(4'd1, 16'h00F0, 16'h0F00, 8'h00, 1'b0, lat);
    accept_out();
    checks++; if (b1.ops_done !== 16'h0000) begin errors++; $display("FAIL wrap_ops_done: got %h expected 0000", b1.ops_done); end
  endtask

  task automatic test_settle3();
    int lat;
    @(negedge clk);
    b3.in_func = 4'd2; b3.in_rs = 16'h1234; b3.in_rt = 16'h0F0F; b3.in_use_imm = 1'b0; b3.in_valid = 1'b1;
    @(posedge clk); #1;
    b3.in_valid = 1'b0;
    lat = 0;
    while (!b3.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 3) begin errors++; $display("FAIL settle3_latency: got %0d expected 3", lat); end
    checks++; if ({b3.alu_op, b3.out_result, b3.out_zero} !== {3'd2, 16'h2143, 1'b0}) begin errors++; $display("FAIL settle3_result: got op=%h r=%h z=%b expected 2 2143 0", b3.alu_op, b3.out_result, b3.out_zero); end
    @(negedge clk); b3.out_ready = 1'b1;
    @(posedge clk); #1; b3.out_ready = 1'b0;
    checks++; if ({b3.out_valid, b3.ops_done} !== {1'b0, 16'd1}) begin errors++; $display("FAIL settle3_handshake: got v=%b n=%h expected 0 0001", b3.out_valid, b3.ops_done); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_imm_ext();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_wrap();
    test_settle3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
